// File: rtl/crc_rtu_tx_sequencer_if.sv
// Signal bundle between the Modbus RTU frame sequencer and its surroundings.
// The surroundings are the frame requester, the payload buffer, the CRC-16 engine and the UART.
//   master : sequencer view (drives buf_addr, crc_*, tx_data/tx_valid, busy/done/err)
//   slave  : environment view (drives frame_start/len, buf_data, crc_busy/value, tx_ready)
interface crc_rtu_tx_sequencer_if;
  logic       frame_start;
  logic [6:0] frame_len;
  logic [5:0] buf_addr;
  logic [7:0] buf_data;
  logic       crc_rst;
  logic       crc_start;
  logic [7:0] crc_byte;
  logic       crc_busy;
  logic [15:0] crc_value;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  frame_start, frame_len, buf_data, crc_busy, crc_value, tx_ready,
    output buf_addr, crc_rst, crc_start, crc_byte, tx_data, tx_valid, busy, done, err
  );

  modport slave (
    output frame_start, frame_len, buf_data, crc_busy, crc_value, tx_ready,
    input  buf_addr, crc_rst, crc_start, crc_byte, tx_data, tx_valid, busy, done, err
  );
endinterface

// File: rtl/crc_rtu_tx_sequencer.sv
// Modbus RTU transmit sequencer: reads a payload from a 1-cycle-latency buffer, feeds each
// byte to an external CRC-16 engine, streams it to a UART with a valid/ready handshake, then
// appends the CRC low byte followed by the high byte.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : crc_rtu_tx_sequencer_if.master (request, buffer, CRC engine, UART, status)
// Parameters: MAX_LEN (max payload bytes, 2..64), TMO_CYC (CRC-busy watchdog limit).
// Optional feature: define CRC_SEQ_WATCHDOG_EN to abort a frame when crc_busy stays high for
// TMO_CYC cycles in the WAIT state.
module crc_rtu_tx_sequencer #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned TMO_CYC = 16
) (
  input logic                    clk,
  input logic                    reset_n,
  crc_rtu_tx_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StClr, StFetch, StLoad, StPulse, StArm, StWait, StSend, StCrcLo, StCrcHi
  } state_e;

  localparam logic [6:0] MaxLen = 7'(MAX_LEN);

  state_e     state_q, state_d;
  logic [6:0] len_q, len_d;
  logic [6:0] idx_q, idx_d;
  logic [6:0] idx_inc;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       tx_valid_q, tx_valid_d;
  logic       crc_start_q, crc_start_d;
  logic       crc_rst_q, crc_rst_d;
  logic [5:0] buf_addr_q, buf_addr_d;
  logic [7:0] crc_byte_q, crc_byte_d;
  logic [7:0] tx_data_q, tx_data_d;

`ifdef CRC_SEQ_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TMO_CYC + 1);
  logic [WdW-1:0] wd_q, wd_d;
`else
  // Keeps the parameter referenced when the watchdog is compiled out.
  logic [31:0] unused_tmo;
  assign unused_tmo = TMO_CYC;
`endif

  assign idx_inc = idx_q + 7'd1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    tx_valid_d  = tx_valid_q;
    buf_addr_d  = buf_addr_q;
    crc_byte_d  = crc_byte_q;
    tx_data_d   = tx_data_q;
    // Pulse outputs default low every cycle.
    done_d      = 1'b0;
    err_d       = 1'b0;
    crc_start_d = 1'b0;
    crc_rst_d   = 1'b0;
`ifdef CRC_SEQ_WATCHDOG_EN
    wd_d        = wd_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.frame_start) begin
          if ((bus.frame_len != 7'd0) && (bus.frame_len <= MaxLen)) begin
            len_d     = bus.frame_len;
            idx_d     = 7'd0;
            busy_d    = 1'b1;
            crc_rst_d = 1'b1;
            state_d   = StClr;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StClr: begin
        buf_addr_d = idx_q[5:0];
        state_d    = StFetch;
      end
      // Buffer samples buf_addr at the end of FETCH; data is valid during LOAD.
      StFetch: state_d = StLoad;
      StLoad: begin
        crc_byte_d  = bus.buf_data;
        tx_data_d   = bus.buf_data;
        crc_start_d = 1'b1;
        state_d     = StPulse;
      end
      StPulse: state_d = StArm;
      // The engine may take a cycle to raise crc_busy, so ARM never looks at it.
      StArm: begin
        state_d = StWait;
`ifdef CRC_SEQ_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      StWait: begin
        if (!bus.crc_busy) begin
          tx_valid_d = 1'b1;
          state_d    = StSend;
`ifdef CRC_SEQ_WATCHDOG_EN
        end else if (wd_q == WdW'(TMO_CYC - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      StSend: begin
        if (bus.tx_ready) begin
          idx_d = idx_inc;
          if (idx_inc < len_q) begin
            tx_valid_d = 1'b0;
            buf_addr_d = idx_inc[5:0];
            state_d    = StFetch;
          end else begin
            // tx_valid stays high: the CRC low byte follows immediately.
            tx_data_d = bus.crc_value[7:0];
            state_d   = StCrcLo;
          end
        end
      end
      StCrcLo: begin
        if (bus.tx_ready) begin
          tx_data_d = bus.crc_value[15:8];
          state_d   = StCrcHi;
        end
      end
      StCrcHi: begin
        if (bus.tx_ready) begin
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
      crc_start_q <= 1'b0;
      crc_rst_q   <= 1'b0;
      buf_addr_q  <= '0;
      crc_byte_q  <= '0;
      tx_data_q   <= '0;
`ifdef CRC_SEQ_WATCHDOG_EN
      wd_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tx_valid_q  <= tx_valid_d;
      crc_start_q <= crc_start_d;
      crc_rst_q   <= crc_rst_d;
      buf_addr_q  <= buf_addr_d;
      crc_byte_q  <= crc_byte_d;
      tx_data_q   <= tx_data_d;
`ifdef CRC_SEQ_WATCHDOG_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.crc_start = crc_start_q;
  assign bus.crc_rst   = crc_rst_q;
  assign bus.crc_byte  = crc_byte_q;
  assign bus.buf_addr  = buf_addr_q;

endmodule

// File: tb/tb_crc_rtu_tx_sequencer.sv
// Bench for crc_rtu_tx_sequencer: buffer and CRC-engine models, scoreboard of expected UART
// bytes, and a monitor that pops and compares on every handshake.
module tb_crc_rtu_tx_sequencer;
  localparam int unsigned MaxLen = 32;
  localparam int unsigned TmoCyc = 16;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  crc_rtu_tx_sequencer_if bus ();

  crc_rtu_tx_sequencer #(
    .MAX_LEN(MaxLen),
    .TMO_CYC(TmoCyc)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int   total = 0;
  int   bad = 0;
  logic [7:0] mem [64];
  logic [7:0] exp_q[$];
  int   frame_xfers = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   rdy_mode = 0;
  int   rdy_phase = 0;
  int   max_lat = 3;
  logic stuck_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Modbus CRC-16: init FFFF, reflected poly A001, low byte sent first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  function automatic bq_t build_expect(input bq_t d);
    bq_t e;
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (d[i]) begin
      c = crc_step(c, d[i]);
      e.push_back(d[i]);
    end
    e.push_back(c[7:0]);
    e.push_back(c[15:8]);
    return e;
  endfunction

  // Payload buffer with one-cycle read latency.
  always @(posedge clk) bus.buf_data <= mem[bus.buf_addr];

  // CRC engine: acts on the rising edge of crc_start, busy for 1..max_lat cycles.
  logic        eng_busy;
  logic        start_prev;
  logic [15:0] pend;
  int          eng_cnt;
  always @(posedge clk) begin
    start_prev <= bus.crc_start;
    if (!reset_n || bus.crc_rst) begin
      if (bus.crc_rst) bus.crc_value <= 16'hFFFF;
      eng_busy <= 1'b0;
      eng_cnt  <= 0;
    end else if (bus.crc_start && !start_prev) begin
      pend     <= crc_step(bus.crc_value, bus.crc_byte);
      eng_busy <= 1'b1;
      eng_cnt  <= $urandom_range(max_lat, 1);
    end else if (eng_cnt > 0) begin
      if (eng_cnt == 1) begin
        bus.crc_value <= pend;
        eng_busy      <= 1'b0;
      end
      eng_cnt <= eng_cnt - 1;
    end
  end
  assign bus.crc_busy = eng_busy | stuck_busy;

  // UART ready generator.
  initial begin
    bus.tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rdy_phase++;
      case (rdy_mode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = ((rdy_phase / 3) % 2) == 0;
        2:       bus.tx_ready = 1'($urandom_range(1, 0));
        3:       bus.tx_ready = (frame_xfers < 2);
        default: bus.tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares at the negedge before the edge on which a transfer happens.
  logic       stall_pending = 1'b0;
  logic [7:0] stall_data;
  logic       start_seen_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.crc_start) check("crc_start_gap", 32'(start_seen_prev), 0);
        start_seen_prev = bus.crc_start;
        if (stall_pending) begin
          check("tx_hold_valid", 32'(bus.tx_valid), 1);
          check("tx_hold_data", 32'(bus.tx_data), 32'(stall_data));
          stall_pending = 1'b0;
        end
        if (bus.tx_valid && bus.tx_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL tx_unexpected: got %0h expected no transfer", bus.tx_data);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (bus.tx_data !== e) begin
              bad++;
              $display("FAIL tx_byte: got %0h expected %0h", bus.tx_data, e);
            end
          end
          frame_xfers++;
        end else if (bus.tx_valid) begin
          stall_pending = 1'b1;
          stall_data    = bus.tx_data;
        end
        if (bus.done) begin
          done_cnt++;
          check("done_after_last", 32'(exp_q.size()), 0);
        end
        if (bus.err) err_cnt++;
      end else begin
        stall_pending   = 1'b0;
        start_seen_prev = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic start_frame(input bq_t data, input logic [6:0] len, input bq_t expect_b);
    foreach (data[i]) mem[i] = data[i];
    foreach (expect_b[i]) exp_q.push_back(expect_b[i]);
    frame_xfers = 0;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b1;
    bus.frame_len   = len;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_done_once"}, 32'(done_cnt - d0), 1);
    check({name, "_busy_low"}, 32'(bus.busy), 0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 0);
  endtask

  task automatic reject(input logic [6:0] len);
    int e0;
    e0 = err_cnt;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b1;
    bus.frame_len   = len;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    check("rej_err", 32'(bus.err), 1);
    check("rej_busy", 32'(bus.busy), 0);
    repeat (6) @(posedge clk);
    #1;
    check("rej_err_once", 32'(err_cnt - e0), 1);
    check("rej_no_valid", 32'(bus.tx_valid), 0);
    check("rej_busy_after", 32'(bus.busy), 0);
  endtask

  bq_t modbus;
  bq_t modbus_exp;
  int  exp_err = 0;

  initial begin
    bq_t d;
    bq_t e;
    bit  hit;
    int  k;
    int  e0;
    int  d0;
    int  len;
    bus.frame_start = 1'b0;
    bus.frame_len   = '0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    modbus     = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
    modbus_exp = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};

    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_tx_valid", 32'(bus.tx_valid), 0);
    check("rst_crc_start", 32'(bus.crc_start), 0);
    check("rst_crc_rst", 32'(bus.crc_rst), 0);
    check("rst_buf_addr", 32'(bus.buf_addr), 0);
    check("rst_crc_byte", 32'(bus.crc_byte), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Reference Modbus read request, always ready.
    rdy_mode = 0;
    start_frame(modbus, 7'd6, modbus_exp);
    wait_done("modbus_rdy", 400);

    // Same frame, ready toggling every three cycles.
    rdy_mode = 1;
    start_frame(modbus, 7'd6, modbus_exp);
    wait_done("modbus_toggle", 600);

    // Length rejection on both sides of the legal range.
    rdy_mode = 0;
    reject(7'd0);
    reject(7'(MaxLen + 1));
    exp_err += 2;

    // frame_start mid-frame is ignored.
    rdy_mode = 2;
    d = {};
    for (int i = 0; i < 5; i++) d.push_back(8'($urandom));
    start_frame(d, 7'd5, build_expect(d));
    repeat (10) @(posedge clk);
    #1;
    bus.frame_start = 1'b1;
    bus.frame_len   = 7'd3;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    wait_done("midstart", 800);
    check("midstart_xfers", 32'(frame_xfers), 7);
    repeat (20) @(posedge clk);

    // Reset during the third SEND abandons the frame.
    rdy_mode = 3;
    start_frame(modbus, 7'd6, modbus_exp);
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_xfers == 2 && bus.tx_valid && !bus.tx_ready) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reached_send3", 32'(hit), 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_tx_valid", 32'(bus.tx_valid), 0);
    exp_q.delete();
    rdy_mode = 0;
    reset_n  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 0);
    start_frame(modbus, 7'd6, modbus_exp);
    wait_done("after_abort", 400);

    // Randomised frames including the length boundaries.
    for (int n = 0; n < 6; n++) begin
      len = (n == 0) ? MaxLen : (n == 1) ? 1 : int'($urandom_range(MaxLen, 1));
      rdy_mode = int'($urandom_range(2, 0));
      max_lat  = int'($urandom_range(4, 1));
      d = {};
      for (int i = 0; i < len; i++) d.push_back(8'($urandom));
      e = build_expect(d);
      start_frame(d, 7'(len), e);
      wait_done("random", 64 * len + 200);
      check("random_xfers", 32'(frame_xfers), 32'(len + 2));
    end

    // CRC engine stuck busy.
    rdy_mode = 0;
    max_lat  = 2;
    stuck_busy = 1'b1;
    e0 = err_cnt;
    d = '{8'h5A, 8'hC3};
`ifdef CRC_SEQ_WATCHDOG_EN
    start_frame(d, 7'd2, build_expect(d));
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.crc_start) begin
        hit = 1'b1;
        break;
      end
    end
    check("wd_pulse_seen", 32'(hit), 1);
    k = 0;
    for (int i = 0; i < 4 * TmoCyc + 10; i++) begin
      @(negedge clk);
      k++;
      if (bus.err) break;
    end
    check("wd_delay", 32'(k), 32'(TmoCyc + 2));
    check("wd_busy", 32'(bus.busy), 0);
    check("wd_tx_valid", 32'(bus.tx_valid), 0);
    stuck_busy = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.delete();
    exp_err += 1;
    check("wd_err_once", 32'(err_cnt - e0), 1);
`else
    start_frame(d, 7'd2, build_expect(d));
    repeat (3 * TmoCyc + 10) @(posedge clk);
    #1;
    check("nowd_no_err", 32'(err_cnt - e0), 0);
    check("nowd_busy", 32'(bus.busy), 1);
    check("nowd_no_valid", 32'(bus.tx_valid), 0);
    stuck_busy = 1'b0;
    wait_done("nowd_release", 300);
`endif

    repeat (5) @(posedge clk);
    check("err_total", 32'(err_cnt), 32'(exp_err));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
